// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory-port arbiter, its two requesters (IF, DATA) and memory.
// The master modport is the arbiter's view; slave is the surrounding core/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_done;
    logic            if_err;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_done;
    logic            d_err;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;
    logic            mem_err;

    logic            arb_eqmem;
    logic            memOp_done;
    logic            stall_mem;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_ready, mem_rdata, mem_err,
        output if_rdata, if_done, if_err, d_rdata, d_done, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               arb_eqmem, memOp_done, stall_mem
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_ready, mem_rdata, mem_err,
        input  if_rdata, if_done, if_err, d_rdata, d_done, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               arb_eqmem, memOp_done, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. DATA has priority,
// a starvation counter forces an IF grant after STARVE_MAX DATA grants with IF waiting.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               nrst,
    mem_port_arbiter_if.master bus
);
    localparam int         BW   = DW / 8;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_I_BUSY,
        S_D_BUSY,
        S_I_DONE,
        S_D_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_starve;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [DW-1:0]   r_wdata;
    logic [BW-1:0]   r_be;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_if_err;
    logic            r_d_err;

    logic            w_arb_pt;
    logic            w_if_elig;
    logic            w_d_elig;
    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_busy;

    // The requester served in a DONE cycle is masked so it cannot be issued twice.
    assign w_arb_pt  = (r_state == S_IDLE) || (r_state == S_I_DONE) || (r_state == S_D_DONE);
    assign w_if_elig = bus.if_req && (r_state != S_I_DONE);
    assign w_d_elig  = bus.d_req  && (r_state != S_D_DONE);
    assign w_grant_d = w_arb_pt && w_d_elig && !(w_if_elig && (r_starve == SMAX));
    assign w_grant_i = w_arb_pt && !w_grant_d && w_if_elig;
    assign w_busy    = (r_state == S_I_BUSY) || (r_state == S_D_BUSY);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_I_BUSY: if (bus.mem_ready) w_next = S_I_DONE;
            S_D_BUSY: if (bus.mem_ready) w_next = S_D_DONE;
            default: begin
                if (w_grant_d)      w_next = S_D_BUSY;
                else if (w_grant_i) w_next = S_I_BUSY;
                else                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_starve <= 4'd0;
        end else if (w_grant_i || (w_arb_pt && !bus.if_req)) begin
            r_starve <= 4'd0;
        end else if (w_grant_d && bus.if_req && (r_starve != SMAX)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Transfer fields are frozen at the grant edge; requester inputs are ignored afterwards.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_if_rdata <= '0;
            r_if_err   <= 1'b0;
            r_d_rdata  <= '0;
            r_d_err    <= 1'b0;
        end else begin
            if (w_grant_d) begin
                r_addr  <= bus.d_addr;
                r_we    <= bus.d_we;
                r_wdata <= bus.d_wdata;
                r_be    <= bus.d_be;
            end else if (w_grant_i) begin
                r_addr  <= bus.if_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_be    <= '1;
            end
            if (bus.mem_ready && (r_state == S_I_BUSY)) begin
                r_if_rdata <= bus.mem_rdata;
                r_if_err   <= bus.mem_err;
            end
            if (bus.mem_ready && (r_state == S_D_BUSY)) begin
                r_d_rdata <= bus.mem_rdata;
                r_d_err   <= bus.mem_err;
            end
        end
    end

    assign bus.mem_req    = w_busy;
    assign bus.mem_we     = w_busy && r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.mem_be     = r_be;

    assign bus.if_done    = (r_state == S_I_DONE);
    assign bus.if_rdata   = r_if_rdata;
    assign bus.if_err     = r_if_err;
    assign bus.d_done     = (r_state == S_D_DONE);
    assign bus.d_rdata    = r_d_rdata;
    assign bus.d_err      = r_d_err;

    assign bus.arb_eqmem  = (r_state == S_D_BUSY) || (r_state == S_D_DONE);
    assign bus.memOp_done = (r_state == S_D_DONE);
    assign bus.stall_mem  = bus.if_req && (r_state != S_I_DONE);
endmodule
